// File: rtl/elevator_scheduler.sv
// SCAN elevator controller: latches hall/car calls, tracks position from
// one-hot floor sensors, drives motor and a timed door.
module elevator_scheduler #(
    parameter int FLOORS      = 4,
    parameter int DOOR_CYCLES = 8,
    localparam int FW         = $clog2(FLOORS)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [FLOORS-1:0] sensor,
    input  logic [FLOORS-1:0] hall_up,
    input  logic [FLOORS-1:0] hall_dn,
    input  logic [FLOORS-1:0] car_call,
    output logic              up,
    output logic              down,
    output logic              stop,
    output logic              open_door,
    output logic [FW-1:0]     monitor,
    output logic              dir_up,
    output logic [FLOORS-1:0] pending
);

    typedef enum logic [1:0] {IDLE, MOVE_UP, MOVE_DN, DOOR_OPEN} state_e;

    localparam int CW = (DOOR_CYCLES > 1) ? $clog2(DOOR_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_LOAD = CW'(DOOR_CYCLES - 1);
    localparam logic [FLOORS-1:0] BOT = {{(FLOORS-1){1'b0}}, 1'b1};
    localparam logic [FLOORS-1:0] TOP = {1'b1, {(FLOORS-1){1'b0}}};

    state_e            state_q, state_d;
    logic [FW-1:0]     monitor_q, monitor_d;
    logic              dir_q, dir_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [FLOORS-1:0] rq_up_q, rq_up_d;
    logic [FLOORS-1:0] rq_dn_q, rq_dn_d;
    logic [FLOORS-1:0] rq_car_q, rq_car_d;

    logic [FLOORS-1:0] req, fm_m, fm_s, fm_c;
    logic [FLOORS-1:0] blk_car, blk_up, blk_dn;
    logic [FLOORS-1:0] clr_car, clr_up, clr_dn;
    logic [FLOORS-1:0] up_in, dn_in;
    logic [FW-1:0]     sidx, clr_f;
    logic              svalid, here, above, below;
    logic              in_door, reload, clr_en;

    function automatic logic any_gt(input logic [FLOORS-1:0] r,
                                    input logic [FW-1:0] f);
        logic a;
        a = 1'b0;
        for (int i = 0; i < FLOORS; i++)
            if (FW'(i) > f && r[i]) a = 1'b1;
        return a;
    endfunction

    function automatic logic any_lt(input logic [FLOORS-1:0] r,
                                    input logic [FW-1:0] f);
        logic a;
        a = 1'b0;
        for (int i = 0; i < FLOORS; i++)
            if (FW'(i) < f && r[i]) a = 1'b1;
        return a;
    endfunction

    always_comb begin
        sidx = '0;
        for (int i = 0; i < FLOORS; i++)
            if (sensor[i]) sidx = FW'(i);
    end

    assign svalid    = $onehot(sensor);
    assign monitor_d = svalid ? sidx : monitor_q;
    assign req       = rq_up_q | rq_dn_q | rq_car_q;
    assign fm_m      = BOT << monitor_q;
    assign fm_s      = BOT << sidx;
    assign here      = |(req & fm_m);
    assign above     = any_gt(req, monitor_q);
    assign below     = any_lt(req, monitor_q);

    // Presses at the open door's floor hold the door instead of latching
    assign in_door = (state_q == DOOR_OPEN);
    assign blk_car = in_door ? fm_m : '0;
    assign blk_up  = (in_door && dir_q) ? fm_m : '0;
    assign blk_dn  = (in_door && !dir_q) ? fm_m : '0;
    assign up_in   = hall_up & ~TOP;
    assign dn_in   = hall_dn & ~BOT;
    assign reload  = (|(car_call & blk_car)) || (|(up_in & blk_up))
                  || (|(dn_in & blk_dn));

    always_comb begin
        state_d = state_q;
        dir_d   = dir_q;
        cnt_d   = cnt_q;
        clr_en  = 1'b0;
        clr_f   = monitor_q;
        unique case (state_q)
            IDLE: begin
                if (here) begin
                    state_d = DOOR_OPEN;
                    clr_en  = 1'b1;
                    cnt_d   = CNT_LOAD;
                end else if (above && (dir_q || !below)) begin
                    state_d = MOVE_UP;
                    dir_d   = 1'b1;
                end else if (below) begin
                    state_d = MOVE_DN;
                    dir_d   = 1'b0;
                end
            end
            MOVE_UP: begin
                if (svalid) begin
                    if ((|(rq_car_q & fm_s)) || (|(rq_up_q & fm_s))
                        || ((|(rq_dn_q & fm_s)) && !any_gt(req, sidx))) begin
                        state_d = DOOR_OPEN;
                        clr_en  = 1'b1;
                        clr_f   = sidx;
                        cnt_d   = CNT_LOAD;
                    end else if (sidx == FW'(FLOORS - 1)) begin
                        state_d = IDLE;
                    end
                end
            end
            MOVE_DN: begin
                if (svalid) begin
                    if ((|(rq_car_q & fm_s)) || (|(rq_dn_q & fm_s))
                        || ((|(rq_up_q & fm_s)) && !any_lt(req, sidx))) begin
                        state_d = DOOR_OPEN;
                        clr_en  = 1'b1;
                        clr_f   = sidx;
                        cnt_d   = CNT_LOAD;
                    end else if (sidx == '0) begin
                        state_d = IDLE;
                    end
                end
            end
            DOOR_OPEN: begin
                if (reload)
                    cnt_d = CNT_LOAD;
                else if (cnt_q == '0)
                    state_d = IDLE;
                else
                    cnt_d = cnt_q - 1'b1;
            end
            default: state_d = IDLE;
        endcase
    end

    assign fm_c    = BOT << clr_f;
    assign clr_car = clr_en ? fm_c : '0;
    assign clr_up  = (clr_en && (dir_q || !any_lt(req, clr_f))) ? fm_c : '0;
    assign clr_dn  = (clr_en && (!dir_q || !any_gt(req, clr_f))) ? fm_c : '0;

    // Clear wins over a same-edge press
    assign rq_car_d = (rq_car_q | (car_call & ~blk_car)) & ~clr_car;
    assign rq_up_d  = (rq_up_q | (up_in & ~blk_up)) & ~clr_up;
    assign rq_dn_d  = (rq_dn_q | (dn_in & ~blk_dn)) & ~clr_dn;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= IDLE;
            monitor_q <= '0;
            dir_q     <= 1'b1;
            cnt_q     <= '0;
            rq_up_q   <= '0;
            rq_dn_q   <= '0;
            rq_car_q  <= '0;
        end else begin
            state_q   <= state_d;
            monitor_q <= monitor_d;
            dir_q     <= dir_d;
            cnt_q     <= cnt_d;
            rq_up_q   <= rq_up_d;
            rq_dn_q   <= rq_dn_d;
            rq_car_q  <= rq_car_d;
        end
    end

    assign up        = (state_q == MOVE_UP);
    assign down      = (state_q == MOVE_DN);
    assign stop      = (state_q == IDLE) || (state_q == DOOR_OPEN);
    assign open_door = (state_q == DOOR_OPEN);
    assign monitor   = monitor_q;
    assign dir_up    = dir_q;
    assign pending   = req;

endmodule
